// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: streams consecutive words from the fetch PC
// into a small FIFO drained by the CPU fetch stage; a redirect flushes and restarts.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  input  logic        instr_ready_in,
  output logic [31:0] mem_address_out,
  output logic        mem_sel_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_REQ     = 2'd1,
    ST_IDLE    = 2'd2
  } state_t;

  state_t        state_r;
  logic [31:0]   fetch_pc_r;
  logic          sel_r;
  logic          valid_r;
  logic [31:0]   fifo_data_r [DEPTH];
  logic [31:0]   fifo_pc_r   [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_next_s;
  logic [31:0]   fetch_pc_inc_s;

  // Handshake decode and next occupancy (a pop in the same cycle frees a slot)
  always_comb begin
    push_s         = (state_r == ST_REQ) && sel_r && mem_ready_in;
    pop_s          = valid_r && instr_ready_in;
    count_next_s   = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    fetch_pc_inc_s = fetch_pc_r + 32'd4;
  end

  // FIFO storage: written on capture, no reset needed for the data itself
  always_ff @(posedge clk) begin
    if (push_s && !reset && !redirect_in) begin
      fifo_data_r[wr_ptr_r] <= mem_read_value_in;
      fifo_pc_r[wr_ptr_r]   <= fetch_pc_r;
    end else begin
      fifo_data_r[wr_ptr_r] <= fifo_data_r[wr_ptr_r];
      fifo_pc_r[wr_ptr_r]   <= fifo_pc_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and registered head-valid flag
  always_ff @(posedge clk) begin
    if (reset || redirect_in) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CW{1'b0}});
    end
  end

  // Fetch FSM; RESTART drops sel for a cycle so an in-flight stale response is never taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RESTART;
      fetch_pc_r <= {RESET_PC[31:2], 2'b00};
      sel_r      <= 1'b0;
    end else if (redirect_in) begin
      state_r    <= ST_RESTART;
      fetch_pc_r <= {redirect_pc_in[31:2], 2'b00};
      sel_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_RESTART: begin
          state_r    <= ST_REQ;
          fetch_pc_r <= fetch_pc_r;
          sel_r      <= 1'b1;
        end
        ST_REQ: begin
          if (push_s) begin
            fetch_pc_r <= fetch_pc_inc_s;
            if (count_next_s == DEPTH_C) begin
              state_r <= ST_IDLE;
              sel_r   <= 1'b0;
            end else begin
              state_r <= ST_REQ;
              sel_r   <= 1'b1;
            end
          end else begin
            state_r    <= ST_REQ;
            fetch_pc_r <= fetch_pc_r;
            sel_r      <= 1'b1;
          end
        end
        ST_IDLE: begin
          fetch_pc_r <= fetch_pc_r;
          if (count_next_s < DEPTH_C) begin
            state_r <= ST_REQ;
            sel_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            sel_r   <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_RESTART;
          fetch_pc_r <= fetch_pc_r;
          sel_r      <= 1'b0;
        end
      endcase
    end
  end

  assign instr_valid_out     = valid_r;
  assign instr_out           = fifo_data_r[rd_ptr_r];
  assign instr_pc_out        = fifo_pc_r[rd_ptr_r];
  assign mem_address_out     = fetch_pc_r;
  assign mem_sel_out         = sel_r;
  assign mem_write_mask_out  = 4'b0000;
  assign mem_write_value_out = 32'h0000_0000;

endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
- Sequential instruction prefetcher; bus master on the 32-bit memory bus (address/sel/read_value/write_mask/write_value/ready), directly upstream of the RAM.
- Streams consecutive words from a fetch PC into a small FIFO, which the CPU fetch stage drains with a valid/ready handshake.
- A CPU redirect flushes the FIFO and restarts fetching at a new PC.
- Read-only master: write_mask is always 0.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- redirect_in  in  1  flush and restart fetch at redirect_pc_in.
- redirect_pc_in  in  32  new fetch address; bits [1:0] ignored.
- instr_valid_out  out  1  FIFO head valid.
- instr_out  out  32  FIFO head word, unmodified mem_read_value_in.
- instr_pc_out  out  32  address of FIFO head word.
- instr_ready_in  in  1  consumer pops head when instr_valid_out && instr_ready_in.
- mem_address_out  out  32  bus address, always word-aligned.
- mem_sel_out  out  1  bus select.
- mem_write_mask_out  out  4  constant 4'b0000.
- mem_write_value_out  out  32  constant 0.
- mem_read_value_in  in  32  bus read data.
- mem_ready_in  in  1  bus ready; data valid when high while mem_sel_out high.

Behaviour:
- Reset:
  - state=RESTART, fetch_pc=RESET_PC, FIFO empty (count=0).
  - instr_valid_out=0, mem_sel_out=0, mem_address_out=RESET_PC.
- States:
  - RESTART: sel=0 for exactly one cycle; clears the slave's toggling ready. Next state is REQ.
  - REQ: sel=1, address=fetch_pc.
  - IDLE: sel=0; FIFO full.
- REQ, mem_ready_in=1 (capture):
  - Push {fetch_pc, mem_read_value_in}; fetch_pc += 4, wrapping 32'hFFFF_FFFC→0.
  - count_next counts a same-cycle pop.
  - If count_next < DEPTH, stay in REQ with sel held and the new address. The slave returns ready=0 for one cycle, then data. Throughput is one word per 2 cycles.
  - If count_next == DEPTH, go to IDLE.
- IDLE: go to REQ in the cycle after a pop makes count < DEPTH.
- Request gating: a request is never outstanding while the FIFO is full, so no response is ever dropped for lack of space.
- FIFO:
  - Registered with no bypass; a word captured at edge N is visible on instr_* in cycle N+1.
  - Simultaneous push and pop is allowed in any count, including full-with-pop (only reachable from REQ with count==DEPTH-1 plus push).
- Redirect (highest priority, any state):
  - Flush the FIFO (count=0); fetch_pc=redirect_pc_in & ~3; state=RESTART.
  - Any data accepted in the same cycle is discarded.
  - A same-cycle pop is a don't-care because the FIFO is flushed.
  - instr_valid_out=0 the next cycle.
  - The RESTART bubble is mandatory. The slave registers read data from the address present at the clock edge, so a response in flight from the old address must not be accepted.
- Reset mid-operation: returns to reset values on the next edge, regardless of any outstanding bus request.
- Response semantics:
  - mem_ready_in while sel=0 is ignored.
  - Exactly one outstanding request at a time.
- Latency: redirect at cycle 0 → RESTART in cycle 1, REQ in cycle 2, ready in cycle 3, instr_valid_out in cycle 4 (against the toggling-ready RAM).

Test Plan:
- Reset release; RAM preloaded word k = 32'h1000_0000+k; consumer always ready:
  - First instr_valid_out 4 cycles after reset falls, with instr_pc_out=0 and instr_out=32'h1000_0000.
  - Subsequent words every 2 cycles, PCs 4, 8, 12…
- instr_ready_in held 0, DEPTH=4:
  - Exactly 4 bus captures, then mem_sel_out=0 with count 4.
  - Raise ready: first pop yields PC 0; fetch resumes in the next cycle at PC 16.
  - No word lost or duplicated.
- redirect_in with redirect_pc_in=32'h0000_0043 in the same cycle that mem_ready_in=1:
  - That word is discarded and the FIFO is empty next cycle.
  - mem_sel_out=0 for one cycle, then address 32'h0000_0040.
  - First delivered instr_pc_out=32'h40.
- Redirect while waiting (ready=0 cycle) to 32'h80:
  - The stale response from the old address never appears on instr_*.
  - Next delivered PC is 32'h80.
- Redirect to 32'hFFFF_FFF8, consumer ready:
  - Delivers PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
- Reset asserted for one cycle mid-REQ with FIFO holding 2 entries:
  - Next cycle instr_valid_out=0, mem_sel_out=0.
  - Fetch restarts at RESET_PC.
  - mem_write_mask_out is 0 throughout.
